muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage. Sits beside the single-cycle ALU and uses the same operand inputs (i_r, i_s).
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI/MFLO read o_hi/o_lo directly.
- A start/busy/done handshake lets the hazard unit stall the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request. Sampled only when o_busy=0.
- i_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110 and 111 are ignored.
- i_r  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- i_s  in  WIDTH  rt operand: multiplier or divisor.
- i_flush  in  1  abort the in-flight operation (pipeline flush).
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse; HI/LO are valid and updated.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, i_rst=1 at an edge):
  - o_hi=0, o_lo=0, o_busy=0, o_done=0, state=IDLE.
  - Reset overrides every other input, including mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE, i_start=1 at edge E0:
  - Latch operands and signedness. Load the 6-bit iteration counter with WIDTH.
  - Go to MUL for 000/001, or DIV for 010/011. o_busy=1 from E0 onward.
- Signed ops:
  - Operands are converted to magnitudes. 0x80000000 is treated as unsigned magnitude 2^31.
  - Record sign_q = sign(r) XOR sign(s) and sign_r = sign(r).
  - Unsigned ops clear both sign flags.
- MUL state:
  - Shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle.
  - The counter decrements each cycle; at 0 go to FIX.
- DIV state:
  - Restoring division, one quotient bit per cycle.
  - Partial remainder is WIDTH+1 bits to hold the subtract borrow.
- FIX (single cycle):
  - MUL: product negated if sign_q; {HI,LO} <= product.
  - DIV: LO <= quotient, negated if sign_q; HI <= remainder, negated if sign_r.
  - Then go to IDLE. o_busy=0 and o_done=1 for exactly the cycle after the FIX edge.
- Latency: o_busy high for WIDTH+1 = 33 cycles; o_done asserts in cycle 34 after the accepting edge.
- MTHI/MTLO:
  - At E0, HI<=i_r or LO<=i_r.
  - No busy and no done; visible on o_hi/o_lo the next cycle.
- Divide by zero:
  - No exception. Runs full latency.
  - Result LO=all ones, HI=original dividend i_r, regardless of signedness.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No flag.
- i_start while o_busy=1 is ignored. It is not queued.
- i_start in the o_done cycle is accepted, since busy is already 0.
- i_flush:
  - When busy: return to IDLE at that edge; HI/LO unchanged; no o_done.
  - When idle: any i_start in the same cycle is dropped, including MTHI/MTLO.
  - When asserted in the FIX cycle: flush wins; HI/LO not written.
- Unused op codes 110/111 with i_start: no state change.
- HI/LO change only in FIX, on MTHI/MTLO, or on reset.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full product with one combinational multiplier and skip the MUL state (IDLE to FIX).
  - o_busy high 1 cycle; o_done in cycle 2.
  - DIV is unchanged.
- Undefined: iterative multiply as above. No multiplier operator is instantiated.

Test Plan:
- Reset mid-DIV: start DIVU 100/7, assert i_rst at cycle 10 → o_busy=0, o_hi=0, o_lo=0, no o_done afterwards.
- MULT 0xFFFFFFFE (-2) × 0x00000003 → o_busy for 33 cycles, o_done pulse in cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with MULTU → HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU 0x80000000 / 0xFFFFFFFF → LO=0, HI=0x80000000.
- DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x00001234 after full latency.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0xDEADBEEF, then immediate MTLO 0x1 → next cycle o_hi=0xDEADBEEF, o_lo=1, o_busy and o_done never assert.
  - Start MULTU while busy → ignored; result matches the first operation.
- i_flush at cycle 20 of MULTU 5×5 with prior HI/LO=1/2 → returns idle, HI/LO stay 1/2, no o_done.
  - Back-to-back: start MULTU 5×5 again in the o_done cycle of a prior op → accepted; LO=25 after 33 more cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns HI/LO. It is busy for WIDTH+1 cycles per MULT/DIV.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide is unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // mul: {partial product, multiplier}; div: quotient in low half
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_sign_q, r_sign_r, r_div, r_dz, r_done;

  logic               w_accept, w_is_mul, w_is_div, w_neg_r, w_neg_s;
  logic [WIDTH-1:0]   w_mag_r, w_mag_s;
  logic [CW-1:0]      w_cnt_dec;
  logic [WIDTH:0]     w_mul_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
  assign w_is_mul = (i_op[2:1] == 2'b00);
  assign w_is_div = (i_op[2:1] == 2'b01);
  // Signed ops have i_op[0]==0. Negating 0x80..0 yields unsigned magnitude 2^(WIDTH-1).
  assign w_neg_r  = ~i_op[0] & i_r[WIDTH-1];
  assign w_neg_s  = ~i_op[0] & i_s[WIDTH-1];
  assign w_mag_r  = w_neg_r ? -i_r : i_r;
  assign w_mag_s  = w_neg_s ? -i_s : i_s;
  assign w_cnt_dec = r_cnt - CW'(1);

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_shift   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opnd};

  // With a zero divisor the remainder path already rebuilds the original dividend.
  assign w_prod = r_sign_q ? -r_acc : r_acc;
  assign w_quo  = r_dz ? '1 : (r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
`ifdef MULDIV_FAST_MUL_EN
        if (w_is_mul)      w_state_nxt = S_FIX;
`else
        if (w_is_mul)      w_state_nxt = S_MUL;
`endif
        else if (w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (i_flush)                 w_state_nxt = S_IDLE;
        else if (w_cnt_dec == '0)    w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div    <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (i_op == 3'b100) r_hi <= i_r;
          if (i_op == 3'b101) r_lo <= i_r;
          if (w_is_mul || w_is_div) begin
            r_cnt    <= CW'(WIDTH);
            r_rem    <= '0;
            r_div    <= w_is_div;
            r_dz     <= w_is_div && (i_s == '0);
            r_sign_q <= w_neg_r ^ w_neg_s;
            r_sign_r <= w_neg_r;
            if (w_is_div) begin
              r_opnd <= w_mag_s;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_r};
            end else begin
              r_opnd <= w_mag_r;
`ifdef MULDIV_FAST_MUL_EN
              r_acc  <= (2*WIDTH)'(w_mag_r) * (2*WIDTH)'(w_mag_s);
`else
              r_acc  <= {{WIDTH{1'b0}}, w_mag_s};
`endif
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= w_cnt_dec;
        end
        S_DIV: begin
          r_cnt <= w_cnt_dec;
          r_rem <= w_diff[WIDTH] ? w_shift : w_diff;
          r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
        end
        S_FIX: if (!i_flush) begin
          r_done <= 1'b1;
          if (r_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results, corner divides, MTHI/MTLO, flush, reset.
module tb_muldiv_unit;
  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_r, i_s;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;
  int total = 0;
  int bad   = 0;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                         MTHI = 3'b100, MTLO = 3'b101;

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_r(i_r), .i_s(i_s),
    .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next edge (E0); afterwards the bench sits in cycle 1.
  task automatic start_op(input logic [2:0] op, input logic [31:0] r, input logic [31:0] s);
    i_start = 1'b1; i_op = op; i_r = r; i_s = s;
    tick();
    i_start = 1'b0;
  endtask

  // Step until busy drops; n0 is the current cycle number since E0.
  task automatic wait_done(input string tag, input int n0, input int exp_n);
    int n = n0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    chk({tag, "_done"}, 32'(o_done), 32'd1);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      if (o_done || o_busy) seen++;
      tick();
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = 3'b000; i_r = '0; i_s = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_hi", o_hi, 32'h0);
    chk("rst_lo", o_lo, 32'h0);

    // MULT -2 x 3, then MULTU with the same bit patterns
    start_op(MULT, 32'hFFFF_FFFE, 32'h3);
    chk("mult_busy", 32'(o_busy), 32'd1);
    wait_done("mult", 1, 34);
    chk("mult_hi", o_hi, 32'hFFFF_FFFF);
    chk("mult_lo", o_lo, 32'hFFFF_FFFA);
    tick();
    chk("done_pulse", 32'(o_done), 32'd0);
    start_op(MULTU, 32'hFFFF_FFFE, 32'h3);
    wait_done("multu", 1, 34);
    chk("multu_hi", o_hi, 32'h0000_0002);
    chk("multu_lo", o_lo, 32'hFFFF_FFFA);

    // Signed and unsigned divide corners
    start_op(DIV, 32'hFFFF_FFF9, 32'h2);
    wait_done("div", 1, 34);
    chk("div_lo", o_lo, 32'hFFFF_FFFD);
    chk("div_hi", o_hi, 32'hFFFF_FFFF);
    start_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divu_big", 1, 34);
    chk("divu_big_lo", o_lo, 32'h0);
    chk("divu_big_hi", o_hi, 32'h8000_0000);
    start_op(DIVU, 32'h1234, 32'h0);
    wait_done("divu_z", 1, 34);
    chk("divu_z_lo", o_lo, 32'hFFFF_FFFF);
    chk("divu_z_hi", o_hi, 32'h0000_1234);
    start_op(DIV, 32'hFFFF_FFF9, 32'h0);
    wait_done("div_z", 1, 34);
    chk("div_z_lo", o_lo, 32'hFFFF_FFFF);
    chk("div_z_hi", o_hi, 32'hFFFF_FFF9);
    start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 1, 34);
    chk("div_ovf_lo", o_lo, 32'h8000_0000);
    chk("div_ovf_hi", o_hi, 32'h0);

    // MTHI then immediate MTLO: no busy/done
    tick();
    i_start = 1'b1; i_op = MTHI; i_r = 32'hDEAD_BEEF;
    tick();
    chk("mthi_busy", 32'(o_busy), 32'd0);
    chk("mthi_hi", o_hi, 32'hDEAD_BEEF);
    i_op = MTLO; i_r = 32'h1;
    tick();
    i_start = 1'b0;
    chk("mtlo_lo", o_lo, 32'h1);
    chk("mtlo_hi", o_hi, 32'hDEAD_BEEF);
    watch_no_done("mt_quiet", 3);

    // Unused opcode and flush-while-idle must not touch HI/LO
    start_op(3'b110, 32'h5555_5555, 32'h1);
    chk("op110_busy", 32'(o_busy), 32'd0);
    chk("op110_hi", o_hi, 32'hDEAD_BEEF);
    i_flush = 1'b1;
    start_op(MTHI, 32'h7777_7777, 32'h0);
    i_flush = 1'b0;
    chk("flush_idle_hi", o_hi, 32'hDEAD_BEEF);
    chk("flush_idle_busy", 32'(o_busy), 32'd0);

    // Start while busy is ignored
    start_op(DIVU, 32'd84, 32'd2);
    tick(); tick(); tick(); tick();
    i_start = 1'b1; i_op = MULTU; i_r = 32'd100; i_s = 32'd100;
    tick();
    i_start = 1'b0;
    wait_done("ign", 6, 34);
    chk("ign_lo", o_lo, 32'd42);
    chk("ign_hi", o_hi, 32'd0);

    // Flush at cycle 20 of MULTU 5x5 with HI/LO = 1/2
    tick();
    start_op(MTHI, 32'd1, 32'd0);
    start_op(MTLO, 32'd2, 32'd0);
    start_op(MULTU, 32'd5, 32'd5);
    for (int k = 0; k < 19; k++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_busy", 32'(o_busy), 32'd0);
    watch_no_done("flush_nodone", 40);
    chk("flush_hi", o_hi, 32'd1);
    chk("flush_lo", o_lo, 32'd2);

    // Back-to-back: new op accepted in the done cycle
    start_op(MULTU, 32'd3, 32'd4);
    wait_done("b2b_a", 1, 34);
    chk("b2b_a_lo", o_lo, 32'd12);
    start_op(MULTU, 32'd5, 32'd5);
    chk("b2b_busy", 32'(o_busy), 32'd1);
    wait_done("b2b_b", 1, 34);
    chk("b2b_lo", o_lo, 32'd25);
    chk("b2b_hi", o_hi, 32'd0);

    // Reset mid-DIVU
    start_op(DIVU, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_hi", o_hi, 32'd0);
    chk("rstmid_lo", o_lo, 32'd0);
    watch_no_done("rstmid_nodone", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
